// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared front-end definitions: fetch FSM encodings, reset/exception vectors
// and the {pc, inst} record carried through the fetch buffer.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] FS_BOOT = 2'd0;
  localparam logic [1:0] FS_RUN  = 2'd1;
  localparam logic [1:0] FS_HALT = 2'd2;

  localparam logic [WORD_W-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] EXCEPT_PC_DEF = 32'h8000_0004;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: combinational instruction memory port plus the
// valid/ready handshake that hands {pc, inst} to decode.
interface inst_fetch_ctrl_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_inst;
  logic              id_valid;
  logic              id_ready;
  logic [WORD_W-1:0] id_inst;
  logic [WORD_W-1:0] id_pc;
  logic [WORD_W-1:0] id_pc_plus4;

  modport master (
    output imem_addr,
    input  imem_inst,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc,
    output id_pc_plus4
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc,
    input  id_pc_plus4
  );

endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries with a flush that
// discards everything and outranks push/pop in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // blocking = here would make the result depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset because the head entry drives decode-visible
      // outputs directly; a plain RAM without reset would leak X after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one word per cycle into a
// small buffer for decode, and applies exception/redirect flushes.
module inst_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] EXCEPT_PC  = EXCEPT_PC_DEF,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  inst_fetch_ctrl_if.master   fbus,
  input  logic                redirect_valid,
  input  logic [WORD_W-1:0]   redirect_pc,
  input  logic                except_req,
  input  logic                halt_req,
  output logic [WORD_W-1:0]   fetch_cnt
);

  logic [1:0]                   state;
  logic [1:0]                   state_nxt;
  logic [WORD_W-1:0]            pc;
  logic                         flush;
  logic                         push;
  logic                         pop;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  fetch_entry_t                 head;
  fetch_entry_t                 new_entry;

  assign flush     = except_req || redirect_valid;
  assign pop       = fbus.id_ready && !fifo_empty;
  assign push      = (state == FS_RUN) && !flush && (!fifo_full || pop);
  assign new_entry = '{pc: pc, inst: fbus.imem_inst};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      FS_BOOT: state_nxt = FS_RUN;
      FS_RUN:  if (halt_req)  state_nxt = FS_HALT;
      FS_HALT: if (!halt_req) state_nxt = FS_RUN;
      default: state_nxt = FS_BOOT;
    endcase
    if (except_req && state != FS_BOOT) state_nxt = FS_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FS_BOOT;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (except_req)          pc <= EXCEPT_PC;
      else if (redirect_valid) pc <= align_word(redirect_pc);
      else if (push)           pc <= pc + 32'd4;
      if (push) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (new_entry),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fbus.imem_addr   = pc;
  assign fbus.id_valid    = (fifo_count != '0);
  assign fbus.id_inst     = head.inst;
  assign fbus.id_pc       = head.pc;
  assign fbus.id_pc_plus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a stimulus loop queues the expected
// delivery order, a negedge monitor scores every accepted decode handshake.
module tb_inst_fetch_ctrl;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        except_req;
  logic        halt_req;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  // Delivery order worked out by hand from the cycle plan below.
  logic [31:0] exp_list [11] = '{
    32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C,
    32'h0000_0018, 32'h0000_001C,
    32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
    32'hFFFF_FFFC, 32'h0000_0000
  };

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fbus           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .except_req     (except_req),
    .halt_req       (halt_req),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h2009_0001;
      32'h0000_0004: return 32'h200a_0002;
      default:       return addr ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign bus.imem_inst = mem_model(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor; handshakes in a flush cycle are discarded by design.
  always @(negedge clk) begin
    if (!reset && bus.id_valid && bus.id_ready && !redirect_valid && !except_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra actual=%h expected=none", bus.id_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        check("sb_pc",    bus.id_pc,       exp_pc);
        check("sb_inst",  bus.id_inst,     mem_model(exp_pc));
        check("sb_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    except_req     = 1'b0;
    halt_req       = 1'b0;
    bus.id_ready   = 1'b1;
    foreach (exp_list[i]) exp_q.push_back(exp_list[i]);

    @(negedge clk);
    check("rst_id_valid",  {31'd0, bus.id_valid}, 32'd0);
    check("rst_fetch_cnt", fetch_cnt,             32'd0);
    check("rst_imem_addr", bus.imem_addr,         32'd0);
    check("rst_id_pc",     bus.id_pc,             32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int c = 1; c <= 29; c++) begin
      bus.id_ready   = !(c >= 5 && c <= 9) && (c < 29);
      except_req     = (c == 16);
      halt_req       = (c >= 18 && c <= 21);
      redirect_valid = (c == 12 || c == 16 || c == 25);
      case (c)
        12:      redirect_pc = 32'h0000_001B;
        16:      redirect_pc = 32'h0000_0040;
        25:      redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = 32'h0;
      endcase

      @(negedge clk);
      case (c)
        1, 2: begin
          check("boot_id_valid",  {31'd0, bus.id_valid}, 32'd0);
          check("boot_imem_addr", bus.imem_addr,         32'd0);
          check("boot_fetch_cnt", fetch_cnt,             32'd0);
        end
        3: begin
          check("first_id_valid", {31'd0, bus.id_valid}, 32'd1);
          check("first_id_pc",    bus.id_pc,             32'd0);
          check("first_id_inst",  bus.id_inst,           32'h2009_0001);
          check("first_cnt",      fetch_cnt,             32'd1);
        end
        4: begin
          check("second_plus4", bus.id_pc_plus4, 32'd8);
          check("second_inst",  bus.id_inst,     32'h200a_0002);
          check("second_cnt",   fetch_cnt,       32'd2);
        end
        7, 9: begin
          check("stall_imem_addr", bus.imem_addr,         32'h10);
          check("stall_id_valid",  {31'd0, bus.id_valid}, 32'd1);
          check("stall_id_pc",     bus.id_pc,             32'h8);
          check("stall_cnt",       fetch_cnt,             32'd4);
        end
        13: begin
          check("redir_id_valid",  {31'd0, bus.id_valid}, 32'd0);
          check("redir_imem_addr", bus.imem_addr,         32'h18);
          check("redir_cnt",       fetch_cnt,             32'd6);
        end
        14: check("redir_id_pc", bus.id_pc, 32'h18);
        17: begin
          check("exc_id_valid",  {31'd0, bus.id_valid}, 32'd0);
          check("exc_imem_addr", bus.imem_addr,         32'h8000_0004);
          check("exc_cnt",       fetch_cnt,             32'd9);
        end
        18: check("exc_id_pc", bus.id_pc, 32'h8000_0004);
        20, 21: begin
          check("halt_id_valid",  {31'd0, bus.id_valid}, 32'd0);
          check("halt_imem_addr", bus.imem_addr,         32'h8000_000C);
        end
        22, 23: begin
          check("resume_imem_addr", bus.imem_addr, 32'h8000_000C);
          check("resume_cnt",       fetch_cnt,     32'd11);
        end
        26: begin
          check("wrap_id_valid",  {31'd0, bus.id_valid}, 32'd0);
          check("wrap_imem_addr", bus.imem_addr,         32'hFFFF_FFFC);
          check("wrap_cnt0",      fetch_cnt,             32'd13);
        end
        27: begin
          check("wrap_id_pc", bus.id_pc,       32'hFFFF_FFFC);
          check("wrap_plus4", bus.id_pc_plus4, 32'h0);
          check("wrap_cnt1",  fetch_cnt,       32'd14);
        end
        28: begin
          check("wrap_next_pc", bus.id_pc, 32'h0);
          check("wrap_cnt2",    fetch_cnt, 32'd15);
        end
        default: ;
      endcase
      @(posedge clk); #1;
    end

    check("sb_drained", exp_q.size(), 32'd0);

    // Mid-cycle reset with a full buffer must clear outputs immediately.
    #2;
    check("pre_rst_id_valid", {31'd0, bus.id_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_id_valid",  {31'd0, bus.id_valid}, 32'd0);
    check("async_rst_fetch_cnt", fetch_cnt,             32'd0);
    check("async_rst_imem_addr", bus.imem_addr,         32'd0);
    check("async_rst_id_pc",     bus.id_pc,             32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
